// File: rtl/button_ctrl_pkg.sv
// Shared constants and helpers for the front-panel button controller.
package button_ctrl_pkg;

    // Repeat-tracker states, kept as plain constants for legacy tools.
    typedef logic [1:0] rpt_state_t;
    localparam rpt_state_t ST_IDLE   = 2'd0;
    localparam rpt_state_t ST_DELAY  = 2'd1;
    localparam rpt_state_t ST_REPEAT = 2'd2;

    // Bits needed to hold an index/count in 0..n-1 (never less than one bit).
    function automatic int idx_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    // Larger of two integers, used to size the shared repeat counter.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/button_controller_tick_pulser.sv
// One button's strobe-enabled two-stage sampler; q1 is the debounced level
// and rise flags a newly sampled press (q0 set, q1 still clear).
module tick_pulser (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    output logic held,
    output logic rise
);

    logic q0_q;
    logic q1_q;
    logic q0_d;
    logic q1_d;

    // Advance the sampler pipeline only on sample strobes.
    always_comb begin
        if (tick) begin
            q0_d = btn;
            q1_d = q0_q;
        end else begin
            q0_d = q0_q;
            q1_d = q1_q;
        end
    end

    // Sampler flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q0_q <= 1'b0;
            q1_q <= 1'b0;
        end else begin
            q0_q <= q0_d;
            q1_q <= q1_d;
        end
    end

    assign held = q1_q;
    assign rise = q0_q & ~q1_q;

endmodule

// File: rtl/button_controller.sv
// Front-panel button controller: sample strobe, per-button single-pulse
// detection, one shared auto-repeat tracker and a fixed-priority event
// arbiter feeding a valid/ack consumer.
module button_controller
    import button_ctrl_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int DIV          = 250000,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                            iClk,
    input  logic                            iRst_n,
    input  logic [N_BTN-1:0]                iBtn,
    input  logic                            iAck,
    output logic                            oValid,
    output logic [idx_width(N_BTN)-1:0]     oCode,
    output logic                            oRepeat,
    output logic [N_BTN-1:0]                oHeld
);

    localparam int CW = idx_width(N_BTN);
    localparam int TW = idx_width(DIV);
    localparam int RW = idx_width(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

    // Lowest set index of a vector (0 when empty; callers qualify with |v).
    function automatic logic [CW-1:0] lowest_idx(input logic [N_BTN-1:0] v);
        lowest_idx = {CW{1'b0}};
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = CW'(i);
            end else begin
                lowest_idx = lowest_idx;
            end
        end
    endfunction

    logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
    logic             tick_s;
    logic             tick_d_q;
    logic [N_BTN-1:0] held_s;
    logic [N_BTN-1:0] rise_s;
    logic [CW-1:0]    low_held_s;

    rpt_state_t       st_q, st_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             fire_s;

    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] rpt_q, rpt_d;
    logic [N_BTN-1:0] set_s;
    logic [N_BTN-1:0] clr_s;
    logic [CW-1:0]    grant_idx_s;
    logic             take_s;

    logic             valid_q, valid_d;
    logic [CW-1:0]    code_q, code_d;
    logic             rep_q, rep_d;

    // Free-running sample-strobe divider, strobe on the last count.
    always_comb begin
        tick_s = (tick_cnt_q == TW'(DIV - 1));
        if (tick_s) begin
            tick_cnt_d = {TW{1'b0}};
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            tick_pulser u_tp (
                .clk   (iClk),
                .rst_n (iRst_n),
                .tick  (tick_s),
                .btn   (iBtn[gi]),
                .held  (held_s[gi]),
                .rise  (rise_s[gi])
            );
        end
    endgenerate

    assign low_held_s = lowest_idx(held_s);

    // Repeat tracker: follows the lowest held button and fires on countdown.
    always_comb begin
        st_d   = st_q;
        rcnt_d = rcnt_q;
        idx_d  = idx_q;
        fire_s = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (|held_s) begin
                    st_d   = ST_DELAY;
                    rcnt_d = RW'(REPEAT_DELAY);
                    idx_d  = low_held_s;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!held_s[idx_q] || (low_held_s != idx_q)) begin
                    // Released or overtaken by a higher-priority button.
                    st_d = ST_IDLE;
                end else if (tick_s) begin
                    if (rcnt_q == RW'(1)) begin
                        fire_s = 1'b1;
                        rcnt_d = RW'(REPEAT_RATE);
                        st_d   = ST_REPEAT;
                    end else begin
                        rcnt_d = rcnt_q - RW'(1);
                    end
                end else begin
                    st_d = st_q;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // Pending-bit sources: fresh edges (one cycle after a strobe) and repeats.
    always_comb begin
        set_s = {N_BTN{1'b0}};
        rpt_d = rpt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (tick_d_q && rise_s[i]) begin
                set_s[i] = 1'b1;
                rpt_d[i] = 1'b0;
            end else if (fire_s && (idx_q == CW'(i))) begin
                set_s[i] = 1'b1;
                rpt_d[i] = 1'b1;
            end else begin
                set_s[i] = 1'b0;
            end
        end
    end

    // Arbiter: hand the lowest pending button to the consumer when free.
    always_comb begin
        take_s      = !valid_q || iAck;
        grant_idx_s = lowest_idx(pend_q);
        valid_d     = valid_q;
        code_d      = code_q;
        rep_d       = rep_q;
        clr_s       = {N_BTN{1'b0}};
        if (take_s) begin
            if (|pend_q) begin
                valid_d = 1'b1;
                code_d  = grant_idx_s;
                rep_d   = rpt_q[grant_idx_s];
                for (int i = 0; i < N_BTN; i++) begin
                    clr_s[i] = (grant_idx_s == CW'(i));
                end
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
        // A set landing in the same cycle as the grant-clear survives.
        pend_d = (pend_q & ~clr_s) | set_s;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            tick_cnt_q <= {TW{1'b0}};
            tick_d_q   <= 1'b0;
            st_q       <= ST_IDLE;
            rcnt_q     <= {RW{1'b0}};
            idx_q      <= {CW{1'b0}};
            pend_q     <= {N_BTN{1'b0}};
            rpt_q      <= {N_BTN{1'b0}};
            valid_q    <= 1'b0;
            code_q     <= {CW{1'b0}};
            rep_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_d_q   <= tick_s;
            st_q       <= st_d;
            rcnt_q     <= rcnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            rpt_q      <= rpt_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            rep_q      <= rep_d;
        end
    end

    assign oValid  = valid_q;
    assign oCode   = code_q;
    assign oRepeat = rep_q;
    assign oHeld   = held_s;

endmodule

// File: doc/button_controller.md
# button_controller

Front-panel input controller that turns raw push-button levels into acknowledged command events. It generates its own debounce sample strobe and runs a per-button two-stage single-pulse detector on that strobe. Simultaneous presses are arbitrated by fixed priority and queued as pending bits, and a held button auto-repeats. It sits between the board buttons and the lab's command FSM, which consumes one event at a time over a valid/ack handshake.

## Interface
- N_BTN, 4, number of buttons (2..8)
- DIV, 250000, iClk cycles per sample tick (≥2)
- REPEAT_DELAY, 50, ticks a button must be held before the first repeat (≥1)
- REPEAT_RATE, 10, ticks between subsequent repeats (≥1)

- iClk  in  1  system clock; one clock domain, all logic on rising edge
- iRst_n  in  1  reset, synchronous, active-low
- iBtn  in  N_BTN  raw button levels, asynchronous to nothing (board-synchronised upstream), 1 = pressed
- iAck  in  1  consumer accepts current event; meaningful only while oValid=1
- oValid  out  1  event available
- oCode  out  clog2(N_BTN)  index of the button the event belongs to
- oRepeat  out  1  1 = event was generated by auto-repeat, 0 = fresh press
- oHeld  out  N_BTN  debounced button levels (second sampler stage)

## Operation
- Tick counter: counts 0..DIV-1; tick=1 in the cycle the count equals DIV-1, then wraps to 0.
- Sampler, per button, on tick cycles only: q0←iBtn, q1←q0. oHeld=q1.
- Edge detect: tick_d = tick delayed one cycle; on tick_d, edge[i]=q0[i]&~q1[i] sets pend[i] and clears rpt_flag[i].
- Repeat FSM (one instance, tracks lowest-index bit of oHeld):
  - IDLE: no button held. On any held button → DELAY, load cnt=REPEAT_DELAY, latch idx.
  - DELAY: decrement cnt on each tick. At 0 → set pend[idx] and rpt_flag[idx], reload cnt=REPEAT_RATE, → REPEAT.
  - REPEAT: same decrement. At 0 → set pend[idx] and rpt_flag[idx], reload.
  - From DELAY/REPEAT: if oHeld[idx]=0 or lowest held index ≠ idx → IDLE (re-enter DELAY next cycle if another held).
- Arbiter: when oValid=0, or oValid=1 and iAck=1, load lowest-index set pend bit into oCode/oRepeat and set oValid; clear that pend bit. If none pending, oValid←0 after ack.
- A repeat for a button already pending coalesces (single pend bit). A fresh edge for the button currently displayed re-sets pend and it is delivered again after ack.
- Same-cycle set and grant-clear of one pend bit: set wins.

## Timing
- Reset (iRst_n=0 at a clock edge): oValid=0, oCode=0, oRepeat=0, oHeld=0, pend=0, tick count=0, FSM=IDLE, cnt=0. Reset mid-event drops the event with no ack required.
- Latency: button high before tick cycle t, previously low for ≥1 tick → pend set at end of t+1 → oValid=1 at end of t+2 (if arbiter free).
- oCode/oRepeat stable while oValid=1 and iAck=0. iAck with oValid=0 ignored.
- Back-to-back: ack in cycle c with another pend bit set → oValid stays 1, new oCode from cycle c+1.
- First repeat exactly REPEAT_DELAY ticks after FSM enters DELAY; then every REPEAT_RATE ticks.
- Press shorter than one tick period may be missed (debounce by design).

## Structure
- Package button_ctrl_pkg: repeat-FSM state enum (IDLE, DELAY, REPEAT), width helper for oCode and counters.
- Sub-module tick_pulser: one button's enabled two-FF sampler with edge output; instantiated N_BTN times via generate.
- Tick counter, repeat FSM and arbiter live in the top.

## Test plan
Use DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2, N_BTN=4.
- Reset: hold iRst_n=0 for 3 cycles with iBtn=4'b1111 → all outputs 0; after release, first tick at count 3.
- Single press: iBtn[2]=1 for 8 cycles, iAck held 1 → exactly one oValid pulse, oCode=2, oRepeat=0, 2 cycles after the capturing tick.
- Simultaneous press: iBtn=4'b1010 on one tick, iAck=0 for 10 cycles then 1 → oCode=1 until ack, then oCode=3 next cycle, then oValid=0.
- Auto-repeat: hold iBtn[0] for 20 ticks with iAck=1 → first event oRepeat=0, repeat 3 ticks after DELAY entry, then every 2 ticks, all oCode=0, oRepeat=1; release → no further events.
- Coalesce: hold iBtn[3] with iAck=0 for 12 ticks → after ack, at most one further event for code 3.
- Reset mid-event: oValid=1, oCode=1, assert iRst_n=0 for one cycle → oValid=0, pend cleared, no event for button 1 afterwards unless re-pressed.
